// File: rtl/instr_type_pkg.sv
// instr_type: shared types for the immediate-arithmetic execute path.
// EXEC_IMM_ARITH_SERIAL_SHIFT_EN adds the SHIFT state used by the bit-serial shifter.
package instr_type;

   localparam int unsigned IMM_W   = 12;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned SHAMT_W = 5;

   // Opcode class produced by the immediate-arith decoder.
   typedef enum logic [3:0] {
      IAK_ADDI    = 4'd0,
      IAK_SLTI    = 4'd1,
      IAK_SLTIU   = 4'd2,
      IAK_XORI    = 4'd3,
      IAK_ORI     = 4'd4,
      IAK_ANDI    = 4'd5,
      IAK_SLLI    = 4'd6,
      IAK_SRLI    = 4'd7,
      IAK_SRAI    = 4'd8,
      IAK_INVALID = 4'd15
   } imm_arith_kind_t;

   // Execute-stage control state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
      ,
      ST_SHIFT = 2'd2
`endif
   } exec_imm_state_t;

   // True for the three shift opcodes.
   function automatic logic is_shift(input imm_arith_kind_t k);
      return (k == IAK_SLLI) || (k == IAK_SRLI) || (k == IAK_SRAI);
   endfunction

endpackage

// File: rtl/exec_imm_arith_shift.sv
// imm_shift_iter: one-bit-per-cycle shifter with a down-counter of remaining steps.
// Used only when EXEC_IMM_ARITH_SERIAL_SHIFT_EN is defined.
module imm_shift_iter
   import instr_type::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  imm_arith_kind_t    kind,
   input  logic [XLEN-1:0]    data,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [XLEN-1:0]    next_value_c,
   output logic               last_c
);

   logic [XLEN-1:0]    shreg_q, shreg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               arith_q, arith_d;
   logic [XLEN-1:0]    step_c;

   // Value after one more single-bit shift of the working register.
   always_comb begin
      if (left_q) begin
         step_c = {shreg_q[XLEN-2:0], 1'b0};
      end else begin
         step_c = {arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      end
   end

   assign next_value_c = step_c;
   assign last_c       = (cnt_q == SHAMT_W'(1));

   // Load on start, otherwise shift once per cycle while steps remain.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      arith_d = arith_q;
      if (start) begin
         shreg_d = data;
         cnt_d   = shamt;
         left_d  = (kind == IAK_SLLI);
         arith_d = (kind == IAK_SRAI);
      end else if (cnt_q != '0) begin
         shreg_d = step_c;
         cnt_d   = cnt_q - SHAMT_W'(1);
      end
   end

   // Working register and counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         arith_q <= arith_d;
      end
   end

endmodule

// File: rtl/exec_imm_arith.sv
// exec_imm_arith: I-type immediate arithmetic execute stage with a one-deep result register.
// Build macro EXEC_IMM_ARITH_SERIAL_SHIFT_EN selects a bit-serial shifter for slli/srli/srai;
// without it every kind, shifts included, completes in one cycle through a barrel shifter.
module exec_imm_arith
   import instr_type::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  imm_arith_kind_t  in_kind,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [RD_W-1:0]  in_rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [RD_W-1:0]  out_rd,
   output logic             out_we,
   output logic             out_illegal
);

   exec_imm_state_t    state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [XLEN-1:0]    out_result_q, out_result_d;
   logic [RD_W-1:0]    out_rd_q, out_rd_d;
   logic               out_we_q, out_we_d;
   logic               out_illegal_q, out_illegal_d;

   logic               accept_c;
   logic               busy_c;
   logic               legal_c;
   logic [XLEN-1:0]    imm_sext_c;
   logic [XLEN-1:0]    alu_res_c;
   logic [SHAMT_W-1:0] shamt_c;

   assign imm_sext_c = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
   assign shamt_c    = in_imm[SHAMT_W-1:0];

`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
   logic            shift_start_c;
   logic            shift_last_c;
   logic [XLEN-1:0] shift_next_c;

   // A zero shift amount completes through the normal one-cycle path.
   assign shift_start_c = accept_c && is_shift(in_kind) && (shamt_c != '0);
   assign busy_c        = (state_q == ST_SHIFT);

   imm_shift_iter #(
      .XLEN (XLEN)
   ) u_shift (
      .clk          (clk),
      .rst          (rst),
      .start        (shift_start_c),
      .kind         (in_kind),
      .data         (in_rs1),
      .shamt        (shamt_c),
      .next_value_c (shift_next_c),
      .last_c       (shift_last_c)
   );
`else
   assign busy_c = 1'b0;
`endif

   // The output slot frees up in the same cycle it is consumed, allowing one result per cycle.
   assign in_ready = !busy_c && (!out_valid_q || out_ready);
   assign accept_c = in_valid && in_ready;

   // Single-cycle result for the accepted bundle; unknown kinds are flagged illegal.
   always_comb begin
      alu_res_c = '0;
      legal_c   = 1'b1;
      case (in_kind)
         IAK_ADDI:  alu_res_c = in_rs1 + imm_sext_c;
         IAK_SLTI:  alu_res_c = XLEN'($signed(in_rs1) < $signed(imm_sext_c));
         IAK_SLTIU: alu_res_c = XLEN'(in_rs1 < imm_sext_c);
         IAK_XORI:  alu_res_c = in_rs1 ^ imm_sext_c;
         IAK_ORI:   alu_res_c = in_rs1 | imm_sext_c;
         IAK_ANDI:  alu_res_c = in_rs1 & imm_sext_c;
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
         IAK_SLLI, IAK_SRLI, IAK_SRAI: alu_res_c = in_rs1;
`else
         IAK_SLLI:  alu_res_c = in_rs1 << shamt_c;
         IAK_SRLI:  alu_res_c = in_rs1 >> shamt_c;
         IAK_SRAI:  alu_res_c = XLEN'($signed(in_rs1) >>> shamt_c);
`endif
         default:   legal_c = 1'b0;
      endcase
   end

   // Next-state and output register update.
   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q && !out_ready;
      out_result_d  = out_result_q;
      out_rd_d      = out_rd_q;
      out_we_d      = out_we_q;
      out_illegal_d = out_illegal_q;

      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
         ST_SHIFT: begin
            if (shift_last_c) begin
               state_d      = ST_HOLD;
               out_valid_d  = 1'b1;
               out_result_d = shift_next_c;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
         out_rd_d      = in_rd;
         out_we_d      = legal_c && (in_rd != '0);
         out_illegal_d = !legal_c;
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
         if (shift_start_c) begin
            state_d     = ST_SHIFT;
            out_valid_d = 1'b0;
         end else
`endif
         begin
            state_d      = ST_HOLD;
            out_valid_d  = 1'b1;
            out_result_d = alu_res_c;
         end
      end
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_rd_q      <= '0;
         out_we_q      <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_rd_q      <= out_rd_d;
         out_we_q      <= out_we_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_rd      = out_rd_q;
   assign out_we      = out_we_q;
   assign out_illegal = out_illegal_q;

endmodule
